// File: rtl/dmem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dmem_access_ctrl
// Description : Sequences one decoded load/store into a valid/yumi data-memory
//               request, waits for load data, formats byte lanes, and stalls
//               the pipeline while the access is in flight.
//               Optional macro DMEM_TIMEOUT_EN aborts loads stuck in WAIT.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_access_ctrl #(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              issue_v_i,
    input  logic              is_load_op_i,
    input  logic              is_store_op_i,
    input  logic              is_mem_op_i,
    input  logic              is_byte_op_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       store_data_i,
    input  logic [4:0]        rd_addr_i,
    output logic              stall_o,
    output logic              dmem_v_o,
    output logic              dmem_w_o,
    output logic [ADDR_W-1:0] dmem_addr_o,
    output logic [31:0]       dmem_wdata_o,
    output logic [3:0]        dmem_mask_o,
    input  logic              dmem_yumi_i,
    input  logic              dmem_resp_v_i,
    input  logic [31:0]       dmem_rdata_i,
    output logic              wb_v_o,
    output logic [4:0]        wb_rd_o,
    output logic [31:0]       wb_data_o,
    output logic              misaligned_o,
    output logic              timeout_o
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_REQ  = 2'd1;
    localparam logic [1:0] c_WAIT = 2'd2;
    localparam logic [1:0] c_DONE = 2'd3;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_store_data;
    logic [31:0]       r_wb_data;
    logic [4:0]        r_rd;
    logic              r_is_load;
    logic              r_is_store;
    logic              r_is_byte;

    logic              w_new_op;
    logic              w_misaligned;
    logic              w_accept;
    logic              w_timeout;
    logic              w_timed_out_done;
    logic [7:0]        w_rd_lane;
    logic [31:0]       w_rd_fmt;

    assign w_new_op     = (r_state == c_IDLE) && issue_v_i && is_mem_op_i;
    assign w_misaligned = w_new_op && !is_byte_op_i && (addr_i[1:0] != 2'b00);
    assign w_accept     = w_new_op && !w_misaligned;

    // Little-endian lane select: byte offset 0 lives in rdata[7:0].
    assign w_rd_lane = dmem_rdata_i[{r_addr[1:0], 3'b000} +: 8];
    assign w_rd_fmt  = r_is_byte ? {24'h000000, w_rd_lane} : dmem_rdata_i;

`ifdef DMEM_TIMEOUT_EN
    localparam int c_CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [c_CNT_W-1:0] r_wait_cnt;
    logic               r_timed_out;

    // Counter sits at zero outside WAIT, so it is already cleared on entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wait_cnt  <= '0;
            r_timed_out <= 1'b0;
        end else begin
            r_wait_cnt  <= (r_state == c_WAIT) ? r_wait_cnt + 1'b1 : '0;
            r_timed_out <= (r_state == c_WAIT) && !dmem_resp_v_i && w_timeout;
        end
    end

    assign w_timeout        = (r_state == c_WAIT) &&
                              (r_wait_cnt == c_CNT_W'(TIMEOUT_CYCLES - 1));
    assign w_timed_out_done = (r_state == c_DONE) && r_timed_out;
`else
    logic w_unused_timeout_cfg;

    assign w_unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
    assign w_timeout            = 1'b0;
    assign w_timed_out_done     = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: if (w_accept) w_state_nxt = c_REQ;
            c_REQ:  if (dmem_yumi_i) w_state_nxt = r_is_load ? c_WAIT : c_DONE;
            // A response coinciding with the timeout takes priority.
            c_WAIT: if (dmem_resp_v_i || w_timeout) w_state_nxt = c_DONE;
            c_DONE: w_state_nxt = c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= c_IDLE;
            r_addr       <= '0;
            r_store_data <= '0;
            r_wb_data    <= '0;
            r_rd         <= '0;
            r_is_load    <= 1'b0;
            r_is_store   <= 1'b0;
            r_is_byte    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_addr       <= addr_i;
                r_store_data <= store_data_i;
                r_rd         <= rd_addr_i;
                r_is_load    <= is_load_op_i;
                r_is_store   <= is_store_op_i;
                r_is_byte    <= is_byte_op_i;
            end
            if ((r_state == c_WAIT) && dmem_resp_v_i) begin
                r_wb_data <= w_rd_fmt;
            end
        end
    end

    // The issuing cycle stalls combinationally so the op is held for REQ.
    assign stall_o      = w_accept || (r_state == c_REQ) || (r_state == c_WAIT);
    assign misaligned_o = w_misaligned;

    assign dmem_v_o     = (r_state == c_REQ);
    assign dmem_w_o     = (r_state == c_REQ) && r_is_store;
    assign dmem_addr_o  = {r_addr[ADDR_W-1:2], 2'b00};
    assign dmem_wdata_o = r_is_byte ? {4{r_store_data[7:0]}} : r_store_data;
    assign dmem_mask_o  = ((r_state == c_REQ) && r_is_store) ?
                          (r_is_byte ? (4'b0001 << r_addr[1:0]) : 4'b1111) : 4'b0000;

    assign wb_v_o    = (r_state == c_DONE) && r_is_load && !w_timed_out_done;
    assign wb_rd_o   = r_rd;
    assign wb_data_o = r_wb_data;
    assign timeout_o = w_timed_out_done;

endmodule
`default_nettype wire
